// File: rtl/mcu_cfg_sched.sv
// mcu_cfg_sched: MCU-written shadow registers pushed to a valid/ready sink.
// Define MCU_SYNC_EN for a two-flop wr_state synchronizer (async MCU bus).
module mcu_cfg_sched #(
  parameter logic [3:0] RST_LEN = 4'd14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mcu_cs_n,
  input  logic       mcu_wr_n,
  input  logic [3:0] mcu_addr,
  input  logic [7:0] mcu_db,
  output logic       cfg_valid,
  input  logic       cfg_ready,
  output logic [3:0] cfg_addr,
  output logic [7:0] cfg_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        s1_q, s1_d, v1_q, v1_d;
  logic        prev_q, prev_d;
  logic        armed_q, armed_d;
  logic [3:0]  cap_addr_q, cap_addr_d;
  logic [7:0]  cap_db_q, cap_db_d;
  logic [7:0]  shadow_q [14];
  logic [7:0]  shadow_d [14];
  logic [3:0]  len_q, len_d;
  logic [3:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic [3:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        wr_sync, wr_vld, commit;
  logic        is_cmd, is_reg, busy_now;
  logic        cmd_start, cmd_abort, cmd_clr, err_evt;
  logic [3:0]  eff_len;

`ifdef MCU_SYNC_EN
  logic        s2_q, s2_d, v2_q, v2_d;
  assign s2_d    = s1_q;
  assign v2_d    = v1_q;
  assign wr_sync = s2_q;
  assign wr_vld  = v2_q;
`else
  assign wr_sync = s1_q;
  assign wr_vld  = v1_q;
`endif

  assign s1_d    = mcu_cs_n | mcu_wr_n;
  assign v1_d    = 1'b1;
  assign prev_d  = wr_sync;
  // Only arm after a genuine high level: pulses spanning reset never commit.
  assign armed_d = armed_q | (wr_vld & wr_sync);
  assign commit  = armed_q & wr_sync & ~prev_q;

  assign is_cmd    = commit & (cap_addr_q == 4'hF);
  assign is_reg    = commit & (cap_addr_q != 4'hF);
  assign cmd_start = is_cmd & cap_db_q[0];
  assign cmd_abort = is_cmd & cap_db_q[1];
  assign cmd_clr   = is_cmd & cap_db_q[2];
  assign busy_now  = (state_q != S_IDLE);
  assign eff_len   = (len_q > 4'd14) ? 4'd14 : len_q;
  assign err_evt   = (is_reg & busy_now)
                   | (cmd_start & busy_now & ~cmd_abort);
  assign err_d     = (err_q & ~cmd_clr) | err_evt;

  always_comb begin
    cap_addr_d = cap_addr_q;
    cap_db_d   = cap_db_q;
    if (!wr_sync) begin
      cap_addr_d = mcu_addr;
      cap_db_d   = mcu_db;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    len_d    = len_q;
    if (is_reg && !busy_now) begin
      if (cap_addr_q == 4'hE) len_d = cap_db_q[3:0];
      else shadow_d[cap_addr_q] = cap_db_q;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          idx_d   = 4'd0;
          state_d = (eff_len == 4'd0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: state_d = S_SEND;
      S_SEND: begin
        if (valid_q && cfg_ready) begin
          if (idx_q == eff_len - 4'd1) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over the running push; a start in the same word restarts.
    if (busy_now && cmd_abort) begin
      idx_d   = 4'd0;
      state_d = S_IDLE;
      if (cmd_start)
        state_d = (eff_len == 4'd0) ? S_DONE : S_LOAD;
    end
  end

  always_comb begin
    valid_d = (state_d == S_SEND);
    addr_d  = valid_d ? idx_d : 4'd0;
    data_d  = 8'h00;
    if (valid_d)
      data_d = (state_q == S_LOAD) ? shadow_q[idx_q] : data_q;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= 1'b1;
      v1_q       <= 1'b0;
`ifdef MCU_SYNC_EN
      s2_q       <= 1'b1;
      v2_q       <= 1'b0;
`endif
      prev_q     <= 1'b1;
      armed_q    <= 1'b0;
      cap_addr_q <= 4'd0;
      cap_db_q   <= 8'h00;
      shadow_q   <= '{default: 8'h00};
      len_q      <= RST_LEN;
      idx_q      <= 4'd0;
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      addr_q     <= 4'd0;
      data_q     <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      v1_q       <= v1_d;
`ifdef MCU_SYNC_EN
      s2_q       <= s2_d;
      v2_q       <= v2_d;
`endif
      prev_q     <= prev_d;
      armed_q    <= armed_d;
      cap_addr_q <= cap_addr_d;
      cap_db_q   <= cap_db_d;
      shadow_q   <= shadow_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cfg_valid = valid_q;
  assign cfg_addr  = addr_q;
  assign cfg_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mcu_cfg_sched.sv
// tb_mcu_cfg_sched: directed vectors for the MCU config push scheduler.
// Table of push scenarios plus hand sequences for error, abort and reset.
module tb_mcu_cfg_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mcu_cs_n = 1'b1;
  logic       mcu_wr_n = 1'b1;
  logic [3:0] mcu_addr = 4'd0;
  logic [7:0] mcu_db = 8'h00;
  logic       cfg_valid;
  logic       cfg_ready = 1'b1;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       busy, done, err;

  int tests = 0;
  int fails = 0;
  logic [7:0] mdl [14];

  typedef struct {
    logic [3:0] len;
    logic [7:0] base;
    int         stall;
    int         nexp;
  } vec_t;

  vec_t tbl [5];

  always #5 clk = ~clk;

  mcu_cfg_sched dut (
    .clk(clk), .rst(rst),
    .mcu_cs_n(mcu_cs_n), .mcu_wr_n(mcu_wr_n),
    .mcu_addr(mcu_addr), .mcu_db(mcu_db),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mcu_wr(input logic [3:0] a, input logic [7:0] d,
                        input int post);
    @(negedge clk);
    mcu_addr = a;
    mcu_db   = d;
    mcu_cs_n = 1'b0;
    mcu_wr_n = 1'b0;
    repeat (4) @(negedge clk);
    mcu_cs_n = 1'b1;
    mcu_wr_n = 1'b1;
    repeat (post) @(negedge clk);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
    mcu_wr(a, d, 4);
    if (a < 4'd14) mdl[a] = d;
  endtask

  task automatic push(input string nm, input int n, input int stall);
    int k = 0, dn = 0, bc = 0, held = 0, left;
    logic seen = 1'b0, pv = 1'b0, ph = 1'b0, hs;
    logic bz = 1'b0, bg = 1'b0, bs = 1'b0;
    logic [3:0] pa = 4'd0;
    logic [7:0] pd = 8'h00;
    left = stall;
    cfg_ready = 1'b1;
    mcu_wr(4'hF, 8'h01, 0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (busy) begin seen = 1'b1; bc++; end
      if (done) dn++;
      if (!cfg_valid && (cfg_addr != 4'd0 || cfg_data != 8'h00)) bz = 1'b1;
      if (ph && cfg_valid) bg = 1'b1;
      if (pv && !ph && (!cfg_valid || cfg_addr !== pa || cfg_data !== pd))
        bs = 1'b1;
      if (cfg_valid && left > 0) begin
        cfg_ready = 1'b0; left--; held++;
      end else begin
        cfg_ready = 1'b1;
      end
      hs = cfg_valid & cfg_ready;
      if (hs) begin
        chk($sformatf("%s_addr%0d", nm, k), 32'(cfg_addr), 32'(k[3:0]));
        if (k < n)
          chk($sformatf("%s_data%0d", nm, k), 32'(cfg_data), 32'(mdl[k]));
        k++;
      end
      ph = hs; pv = cfg_valid; pa = cfg_addr; pd = cfg_data;
      if (seen && !busy) break;
    end
    cfg_ready = 1'b1;
    chk({nm, "_started"}, 32'(seen), 32'd1);
    chk({nm, "_ended"}, 32'(busy), 32'd0);
    chk({nm, "_words"}, 32'(k), 32'(n));
    chk({nm, "_done"}, 32'(dn), 32'd1);
    chk({nm, "_busycyc"}, 32'(bc), 32'(2 * n + stall + 1));
    chk({nm, "_held"}, 32'(held), 32'(stall));
    chk({nm, "_zero_idle"}, 32'(bz), 32'd0);
    chk({nm, "_gap"}, 32'(bg), 32'd0);
    chk({nm, "_stable"}, 32'(bs), 32'd0);
  endtask

  task automatic chk_outs_zero(input string nm);
    chk({nm, "_valid"}, 32'(cfg_valid), 32'd0);
    chk({nm, "_addr"}, 32'(cfg_addr), 32'd0);
    chk({nm, "_data"}, 32'(cfg_data), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    tbl[0] = '{len: 4'd1,  base: 8'h3C, stall: 0, nexp: 1};
    tbl[1] = '{len: 4'd3,  base: 8'hA1, stall: 5, nexp: 3};
    tbl[2] = '{len: 4'd0,  base: 8'h00, stall: 0, nexp: 0};
    tbl[3] = '{len: 4'd15, base: 8'h10, stall: 0, nexp: 14};
    tbl[4] = '{len: 4'd2,  base: 8'hF0, stall: 2, nexp: 2};
    for (int i = 0; i < 14; i++) mdl[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk_outs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    wr_reg(4'h2, 8'h3C);
    wr_reg(4'hE, 8'h01);
    push("r0_zero", 1, 0);

    foreach (tbl[i]) begin
      for (int j = 0; j < int'(tbl[i].len) && j < 14; j++)
        wr_reg(j[3:0], tbl[i].base + j[7:0]);
      wr_reg(4'hE, {4'h0, tbl[i].len});
      push($sformatf("vec%0d", i), tbl[i].nexp, tbl[i].stall);
    end

    // start, register write and error clear while a push is stalled
    wr_reg(4'hE, 8'h0E);
    cfg_ready = 1'b0;
    mcu_wr(4'hF, 8'h01, 8);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_valid", 32'(cfg_valid), 32'd1);
    chk("stall_data", 32'(cfg_data), 32'(mdl[0]));
    mcu_wr(4'hF, 8'h01, 4);
    chk("restart_err", 32'(err), 32'd1);
    chk("restart_addr", 32'(cfg_addr), 32'd0);
    chk("restart_valid", 32'(cfg_valid), 32'd1);
    mcu_wr(4'h5, 8'h77, 4);
    chk("wr_busy_err", 32'(err), 32'd1);
    mcu_wr(4'hF, 8'h04, 4);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_keeps_busy", 32'(busy), 32'd1);

    dn = 0;
    mcu_wr(4'hF, 8'h02, 0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) dn++;
      if (!cfg_valid) break;
    end
    chk("abort_valid", 32'(cfg_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_nodone", 32'(dn), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    cfg_ready = 1'b1;
    wr_reg(4'hE, 8'h06);
    push("r5_kept", 6, 0);

    // clear and error in the same word, then reset mid push and mid write
    wr_reg(4'hE, 8'h0E);
    cfg_ready = 1'b0;
    mcu_wr(4'hF, 8'h01, 8);
    chk("pre_rst_valid", 32'(cfg_valid), 32'd1);
    mcu_wr(4'hF, 8'h05, 4);
    chk("clr_same_err", 32'(err), 32'd1);
    @(negedge clk);
    mcu_addr = 4'h3;
    mcu_db   = 8'hEE;
    mcu_cs_n = 1'b0;
    mcu_wr_n = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_outs_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    mcu_cs_n = 1'b1;
    mcu_wr_n = 1'b1;
    repeat (6) @(negedge clk);
    chk_outs_zero("post_rst");
    for (int i = 0; i < 14; i++) mdl[i] = 8'h00;
    push("rst_len", 14, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
